// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Round-robin sharing of one BRAM user port between requesters A and B.
//   One access is issued per cycle through registered BRAM drive. Read data
//   is steered back to its issuer by a tag pipeline matched to READ_LATENCY
//   (legal range 1..4).
//   Optional build macro BRAM_ARB_STATS_EN adds a saturating 16-bit
//   conflict counter (conflict_count) with a synchronous clear (stats_clear).
//
// Handshake: x_ready is combinational from this cycle's valids and the
//   round-robin pointer. It is only ever high while x_valid is high, and it
//   is never high during reset. A transfer happens on each clock edge where
//   x_valid && x_ready. The requester holds valid and its fields stable until
//   it sees ready. The read response is a one-cycle x_rvalid pulse with
//   x_rdata. It appears READ_LATENCY+2 cycles after the cycle in which the
//   read was accepted.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [15:0]           conflict_count
`endif
);

  localparam int LAST = READ_LATENCY;

  // Round-robin pointer: 1 means B was granted most recently.
  logic last_b_q, last_b_d;

  logic                  grant_a, grant_b, grant, grant_we;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_wdata;

  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
  logic                  bram_we_q, bram_we_d;

  // Tag pipeline: bit i of tag_vld/tag_id is stage i; id 1 = requester B.
  logic [LAST:0] tag_vld_q, tag_vld_d;
  logic [LAST:0] tag_id_q, tag_id_d;

  logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  rsp_valid;

  // Arbitration: a lone requester wins; on conflict the one not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      grant_a = a_valid && (!b_valid || last_b_q);
      grant_b = b_valid && (!a_valid || !last_b_q);
    end
    grant       = grant_a || grant_b;
    grant_we    = grant_b ? b_we    : a_we;
    grant_addr  = grant_b ? b_addr  : a_addr;
    grant_wdata = grant_b ? b_wdata : a_wdata;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next-state for pointer, issue registers, tag pipeline and read return.
  always_comb begin
    last_b_d    = grant ? grant_b : last_b_q;
    bram_addr_d = grant ? grant_addr : bram_addr_q;
    bram_din_d  = grant ? grant_wdata : bram_din_q;
    bram_we_d   = grant && grant_we;
    tag_vld_d   = {tag_vld_q[LAST-1:0], grant && !grant_we};
    tag_id_d    = {tag_id_q[LAST-1:0], grant_b};
    rsp_valid   = tag_vld_q[LAST];
    a_rvalid_d  = rsp_valid && !tag_id_q[LAST];
    b_rvalid_d  = rsp_valid && tag_id_q[LAST];
    a_rdata_d   = a_rvalid_d ? bram_dout : a_rdata_q;
    b_rdata_d   = b_rvalid_d ? bram_dout : b_rdata_q;
  end

  // All datapath and control state; reset drops any in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q    <= 1'b1;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      last_b_q    <= last_b_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_we_q   <= bram_we_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign bram_we   = bram_we_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] conflict_count_q, conflict_count_d;

  // Saturating count of dual-valid cycles; clear beats increment.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (stats_clear) begin
      conflict_count_d = '0;
    end else if (a_valid && b_valid && (conflict_count_q != 16'hFFFF)) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count_q <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Bench for bram_port_arbiter with a write-first BRAM model on the user port.
//   The expected read data comes from a reference memory that is updated at
//   request acceptance. It is queued as {id, data} and compared as responses
//   return.
module tb_bram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 18;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, a_rvalid, b_rvalid, bram_we;
  logic [DW-1:0] a_rdata, b_rdata, bram_din, bram_dout;
  logic [AW-1:0] bram_addr;
`ifdef BRAM_ARB_STATS_EN
  logic          stats_clear = 1'b0;
  logic [15:0]   conflict_count;
`endif

  int checks = 0;
  int failures = 0;
  int a_rv_cnt = 0;
  int b_rv_cnt = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [0:RL-1];

  // clock
  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout)
`ifdef BRAM_ARB_STATS_EN
    , .stats_clear(stats_clear), .conflict_count(conflict_count)
`endif
  );

  // BRAM model: write-first, addr sampled at the edge, RL cycles to dout.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
  end

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    rd_pipe[0] <= bram_we ? bram_din : mem[bram_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_dout = rd_pipe[RL-1];

  // Scoreboard: compare returning reads first, then queue newly accepted ones.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (a_rvalid) begin
      a_rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_a_unexpected got=%h required=none", a_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({1'b0, a_rdata} !== e) begin
          failures++;
          $display("FAIL sb_a_rdata got=%h required=%h", {1'b0, a_rdata}, e);
        end
      end
    end
    if (b_rvalid) begin
      b_rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_b_unexpected got=%h required=none", b_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({1'b1, b_rdata} !== e) begin
          failures++;
          $display("FAIL sb_b_rdata got=%h required=%h", {1'b1, b_rdata}, e);
        end
      end
    end
    if (!rst) begin
      if (a_valid && a_ready) begin
        if (a_we) ref_mem[a_addr] = a_wdata;
        else exp_q.push_back({1'b0, ref_mem[a_addr]});
      end
      if (b_valid && b_ready) begin
        if (b_we) ref_mem[b_addr] = b_wdata;
        else exp_q.push_back({1'b1, ref_mem[b_addr]});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic access(input bit id, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    if (id) begin
      b_we = we; b_addr = addr; b_wdata = data; b_valid = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = data; a_valid = 1'b1;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? b_ready : a_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL access_timeout got=no_ready required=ready id=%0d", id);
    end
    tick();
    if (id) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d required=0 outstanding", exp_q.size());
    end
  endtask

  task automatic test_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid, bram_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {a_ready, b_ready, a_rvalid, b_rvalid, bram_we});
    end
    checks++;
    if ({a_rdata, b_rdata, bram_din, bram_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", {a_rdata, b_rdata, bram_din, bram_addr});
    end
`ifdef BRAM_ARB_STATS_EN
    checks++;
    if (conflict_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d required=0", conflict_count);
    end
`endif
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat;
    bit seen, b_seen;
    logic [DW-1:0] got;
    access(1'b0, 1'b1, 8'h10, 18'h2ABCD);
    a_we = 1'b0; a_addr = 8'h10; a_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_rd_accept got=%b required=1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    lat = 0; seen = 1'b0; b_seen = 1'b0; got = '0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (b_rvalid) b_seen = 1'b1;
      if (a_rvalid) begin
        seen = 1'b1;
        got = a_rdata;
      end
    end
    checks++;
    if (lat != RL + 2) begin
      failures++;
      $display("FAIL wr_rd_latency got=%0d required=%0d", lat, RL + 2);
    end
    checks++;
    if (got !== 18'h2ABCD) begin
      failures++;
      $display("FAIL wr_rd_data got=%h required=2abcd", got);
    end
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || b_seen || b_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_pulse got=a%b_b%b required=a0_b0", a_rvalid, b_seen);
    end
    wait_drain();
  endtask

  task automatic test_conflict();
    int ta, tb, idx;
    logic [DW-1:0] da, db;
    access(1'b0, 1'b1, 8'h01, 18'h00011);
    access(1'b0, 1'b1, 8'h02, 18'h00022);
    apply_reset();
    a_we = 1'b0; a_addr = 8'h01; a_valid = 1'b1;
    b_we = 1'b0; b_addr = 8'h02; b_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL conflict_first got=%b required=10", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      failures++;
      $display("FAIL conflict_second got=%b required=01", {a_ready, b_ready});
    end
    tick();
    b_valid = 1'b0;
    ta = -1; tb = -1; da = '0; db = '0;
    for (idx = 0; idx < 20; idx++) begin
      @(negedge clk);
      if (a_rvalid && ta < 0) begin ta = idx; da = a_rdata; end
      if (b_rvalid && tb < 0) begin tb = idx; db = b_rdata; end
    end
    checks++;
    if (ta < 0 || tb != ta + 1) begin
      failures++;
      $display("FAIL conflict_order got=a%0d_b%0d required=b_one_after_a", ta, tb);
    end
    checks++;
    if (da !== 18'h00011 || db !== 18'h00022) begin
      failures++;
      $display("FAIL conflict_data got=%h_%h required=00011_00022", da, db);
    end
    wait_drain();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    apply_reset();
    a_rv_cnt = 0;
    b_rv_cnt = 0;
    a_we = 1'b0; a_addr = 8'h01; a_valid = 1'b1;
    b_we = 1'b0; b_addr = 8'h02; b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({a_ready, b_ready} !== exp_g) begin
        failures++;
        $display("FAIL fair_grant%0d got=%b required=%b", i, {a_ready, b_ready}, exp_g);
      end
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    checks++;
    if (a_rv_cnt != 4 || b_rv_cnt != 4) begin
      failures++;
      $display("FAIL fair_pulses got=a%0d_b%0d required=a4_b4", a_rv_cnt, b_rv_cnt);
    end
  endtask

  task automatic test_mixed();
    int we_cnt;
    bit seen;
    logic [DW-1:0] got;
    apply_reset();
    we_cnt = 0; seen = 1'b0; got = '0;
    a_we = 1'b1; a_addr = 8'h05; a_wdata = 18'h3; a_valid = 1'b1;
    @(negedge clk);
    if (bram_we) we_cnt++;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL mixed_wr_accept got=%b required=1", a_ready);
    end
    tick();
    a_we = 1'b0;
    @(negedge clk);
    if (bram_we) we_cnt++;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL mixed_rd_accept got=%b required=1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bram_we) we_cnt++;
      if (a_rvalid && !seen) begin
        seen = 1'b1;
        got = a_rdata;
      end
    end
    checks++;
    if (!seen || got !== 18'h3) begin
      failures++;
      $display("FAIL mixed_rd_data got=%h seen=%b required=00003", got, seen);
    end
    checks++;
    if (we_cnt != 1) begin
      failures++;
      $display("FAIL mixed_we_cycles got=%0d required=1", we_cnt);
    end
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    int rv;
    apply_reset();
    a_we = 1'b0; a_addr = 8'h10; a_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_accept got=%b required=1", a_ready);
    end
    tick();
    rst = 1'b1;
    exp_q.delete();
    b_we = 1'b0; b_addr = 8'h02; b_valid = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid, bram_we, a_rdata, b_rdata, bram_din, bram_addr} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h required=0",
               {a_ready, b_ready, a_rvalid, b_rvalid, bram_we, a_rdata, b_rdata, bram_din, bram_addr});
    end
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_rvalid || b_rvalid) rv++;
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midrst_regrant got=%b required=10", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_rvalid) rv++;
    end
    checks++;
    if (rv != 0) begin
      failures++;
      $display("FAIL midrst_no_rvalid got=%0d required=0", rv);
    end
    wait_drain();
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    a_we = 1'b0; a_addr = 8'h01; b_we = 1'b0; b_addr = 8'h02;
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (5) tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (conflict_count !== 16'd5) begin
      failures++;
      $display("FAIL stats_count got=%0d required=5", conflict_count);
    end
    tick();
    a_valid = 1'b1; b_valid = 1'b1; stats_clear = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0; stats_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (conflict_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_clear got=%0d required=0", conflict_count);
    end
    wait_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_fairness();
    test_mixed();
    test_reset_midflight();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
